// File: rtl/bf16_mul_seq.sv
// Sequential radix-2 shift-add bfloat16 multiplier: raw 16-bit significand product,
// sign, unbounded biased exponent and special-case flags, with valid/ready on both sides.
module bf16_mul_seq #(
    parameter int BIAS = 127,
    parameter int EXPW = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [15:0]     a,
    input  logic [15:0]     b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            prod_sign,
    output logic [EXPW-1:0] prod_exp,
    output logic [15:0]     prod_mant,
    output logic            prod_zero,
    output logic            prod_inf,
    output logic            prod_nan
);

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t          state;
    logic [7:0]      ma, mb;
    logic            sign_q, nan_q, inf_q, zero_q;
    logic [EXPW-1:0] exp_q;
    logic [15:0]     acc;
    logic [2:0]      cnt;

    // Operand decode, evaluated only when the operands are accepted.
    logic [7:0]      ea, eb;
    logic [6:0]      fa, fb;
    logic            a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic            is_nan, is_inf, is_zero;
    logic [EXPW-1:0] exp_sum;

    assign ea = a[14:7];
    assign eb = b[14:7];
    assign fa = a[6:0];
    assign fb = b[6:0];

    assign a_nan  = (ea == 8'hFF) && (fa != 7'd0);
    assign b_nan  = (eb == 8'hFF) && (fb != 7'd0);
    assign a_inf  = (ea == 8'hFF) && (fa == 7'd0);
    assign b_inf  = (eb == 8'hFF) && (fb == 7'd0);
    assign a_zero = (ea == 8'h00);
    assign b_zero = (eb == 8'h00);

    // Priority NaN > Inf > Zero keeps the three flags mutually exclusive.
    assign is_nan  = a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero);
    assign is_inf  = !is_nan && (a_inf || b_inf);
    assign is_zero = !is_nan && !is_inf && (a_zero || b_zero);

    // Range is -127..381, so EXPW=10 bits of two's complement never wrap.
    assign exp_sum = EXPW'({2'b00, ea}) + EXPW'({2'b00, eb}) - EXPW'(BIAS);

    // One partial product per cycle; 0xFF*0xFF=0xFE01 so 16 bits never overflow.
    logic [15:0] addend, acc_next;
    assign addend   = mb[cnt] ? ({8'h00, ma} << cnt) : 16'h0000;
    assign acc_next = acc + addend;

    logic special;
    assign special = nan_q || inf_q || zero_q;

    // NOTE: all state, including operand latches and accumulator, uses non-blocking
    // assignments and is cleared by reset so an aborted multiply leaves nothing behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            ma        <= '0;
            mb        <= '0;
            sign_q    <= 1'b0;
            exp_q     <= '0;
            nan_q     <= 1'b0;
            inf_q     <= 1'b0;
            zero_q    <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            prod_sign <= 1'b0;
            prod_exp  <= '0;
            prod_mant <= '0;
            prod_zero <= 1'b0;
            prod_inf  <= 1'b0;
            prod_nan  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        ma       <= {1'b1, fa};
                        mb       <= {1'b1, fb};
                        sign_q   <= a[15] ^ b[15];
                        exp_q    <= exp_sum;
                        nan_q    <= is_nan;
                        inf_q    <= is_inf;
                        zero_q   <= is_zero;
                        acc      <= '0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= MUL;
                    end
                end
                MUL: begin
                    acc <= acc_next;
                    cnt <= cnt + 3'd1;
                    // The loop runs its full 8 cycles even for specials to keep latency fixed.
                    if (cnt == 3'd7) begin
                        prod_sign <= sign_q;
                        prod_exp  <= special ? '0 : exp_q;
                        prod_mant <= special ? 16'h0000 : acc_next;
                        prod_nan  <= nan_q;
                        prod_inf  <= inf_q;
                        prod_zero <= zero_q;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
